relu_requant_with_mem: RTL and testbench

Post-processing stage directly downstream of the linear layer. It reads M signed 32-bit accumulator words that the linear layer wrote to shared memory, then applies optional ReLU, a rounding arithmetic right shift and saturation to an 8-bit signed activation. It writes each result back to memory as the activation vector for the next layer. It is a bus master on the same shared address/data bus, using the same mem_sel/mem_w protocol.

---
 rtl/nmca_pkg.sv | 35 +++
 rtl/requant_sat.sv | 56 +++++
 rtl/relu_requant_with_mem.sv | 142 ++++++++++++++
 tb/tb_relu_requant_with_mem.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmca_pkg.sv
// Shared definitions for the NMCA datapath blocks.
// Holds the requant FSM state type, saturation-limit helpers derived from the
// output width, and the mem_sel/mem_w encodings used by every bus master on the
// shared address/data bus.
package nmca_pkg;

  // Requant/write-back sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FINISH
  } rrq_state_e;

  // Default activation width and the saturation limits it implies.
  localparam int unsigned OutWidthDefault = 8;

  function automatic int sat_max(input int unsigned width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned width);
    return -(1 << (width - 1));
  endfunction

  localparam int SatMaxDefault = sat_max(OutWidthDefault);
  localparam int SatMinDefault = sat_min(OutWidthDefault);

  // Shared bus protocol encodings.
  localparam logic MemSelRelease = 1'b0;  // address/data buses left floating
  localparam logic MemSelOwn     = 1'b1;  // master drives address_bus
  localparam logic MemWRead      = 1'b0;  // memory drives data_bus this cycle
  localparam logic MemWWrite     = 1'b1;  // master drives data_bus this cycle

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: optional ReLU, rounding arithmetic right shift
// and saturation of a signed accumulator word to a signed activation.
// Ports:
//   x         signed ACC_WIDTH accumulator value
//   shift_amt right-shift amount (0 = no shift, no rounding)
//   relu_en   clamp negative x to 0 before shifting
//   y         signed OUT_WIDTH saturated result
module requant_sat
  import nmca_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic [ACC_WIDTH-1:0]   x,
  input  logic [SHIFT_WIDTH-1:0] shift_amt,
  input  logic                   relu_en,
  output logic [OUT_WIDTH-1:0]   y
);

  localparam logic signed [ACC_WIDTH:0] SatHi = (ACC_WIDTH + 1)'(sat_max(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH:0] SatLo = (ACC_WIDTH + 1)'(sat_min(OUT_WIDTH));

  // One guard bit so the rounding add of a maximal positive value cannot wrap.
  logic signed [ACC_WIDTH:0] a;
  logic signed [ACC_WIDTH:0] rnd;
  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] r;

  always_comb begin
    a   = {x[ACC_WIDTH-1], x};
    rnd = '0;
    sum = a;
    r   = a;
    if (relu_en && x[ACC_WIDTH-1]) begin
      a = '0;
    end
    if (shift_amt != '0) begin
      // Adding half an LSB before the floor shift gives round-half-up.
      rnd = (ACC_WIDTH + 1)'(1) << (shift_amt - SHIFT_WIDTH'(1));
      sum = a + rnd;
      r   = sum >>> shift_amt;
    end else begin
      r = a;
    end

    if (r > SatHi) begin
      y = SatHi[OUT_WIDTH-1:0];
    end else if (r < SatLo) begin
      y = SatLo[OUT_WIDTH-1:0];
    end else begin
      y = r[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/relu_requant_with_mem.sv
// Post-processing bus master: reads M accumulator words from shared memory,
// requantises each (ReLU, rounding shift, saturation) and writes the
// sign-extended activation back, one read and one write cycle per element.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start           begin a run (accepted only in IDLE)
//   in_base         address of accumulator element 0
//   out_base        address of output element 0
//   shift_amt       right-shift amount
//   relu_en         clamp negatives to 0 before shifting
//   mem_w, mem_sel  bus cycle qualifiers
//   done            one-cycle pulse after the last write
//   out_valid       high during each write cycle
//   address_bus     driven while mem_sel=1, else Z
//   data_bus        driven while mem_sel=1 and mem_w=1, else Z
module relu_requant_with_mem
  import nmca_pkg::*;
#(
  parameter int unsigned ACC_WIDTH     = 32,
  parameter int unsigned OUT_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATABUS_WIDTH = 32,
  parameter int unsigned SHIFT_WIDTH   = 5,
  parameter int unsigned M             = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    in_base,
  input  logic [ADDR_WIDTH-1:0]    out_base,
  input  logic [SHIFT_WIDTH-1:0]   shift_amt,
  input  logic                     relu_en,
  output logic                     mem_w,
  output logic                     mem_sel,
  output logic                     done,
  output logic                     out_valid,
  inout  wire  [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus
);

  localparam int unsigned KW = (M > 1) ? $clog2(M) : 1;
  localparam logic [KW-1:0] KLast = KW'(M - 1);

  rrq_state_e             state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [ADDR_WIDTH-1:0]  in_base_q, in_base_d;
  logic [ADDR_WIDTH-1:0]  out_base_q, out_base_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                   relu_q, relu_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [OUT_WIDTH-1:0]   y;

  requant_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_requant_sat (
    .x        (data_bus[ACC_WIDTH-1:0]),
    .shift_amt(shift_q),
    .relu_en  (relu_q),
    .y        (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    data_d     = data_q;
    addr       = '0;
    mem_sel    = MemSelRelease;
    mem_w      = MemWRead;
    out_valid  = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Operands are frozen here so input changes mid-run are harmless.
          in_base_d  = in_base;
          out_base_d = out_base;
          shift_d    = shift_amt;
          relu_d     = relu_en;
          k_d        = '0;
          state_d    = RD;
        end
      end
      RD: begin
        mem_sel = MemSelOwn;
        addr    = in_base_q + ADDR_WIDTH'(k_q);
        data_d  = y;
        state_d = WR;
      end
      WR: begin
        mem_sel   = MemSelOwn;
        mem_w     = MemWWrite;
        out_valid = 1'b1;
        addr      = out_base_q + ADDR_WIDTH'(k_q);
        if (k_q == KLast) begin
          state_d = FINISH;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = RD;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign address_bus = mem_sel ? addr : {ADDR_WIDTH{1'bz}};
  assign data_bus    = (mem_sel && mem_w)
                     ? {{(DATABUS_WIDTH - OUT_WIDTH){data_q[OUT_WIDTH-1]}}, data_q}
                     : {DATABUS_WIDTH{1'bz}};

endmodule

// File: tb/tb_relu_requant_with_mem.sv
// Bench for relu_requant_with_mem: behavioural memory on the shared bus,
// arithmetic reference model of the requantiser, per-cycle bus checks.
module tb_relu_requant_with_mem;

  localparam int M = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_base = '0;
  logic [7:0] out_base = '0;
  logic [4:0] shift_amt = '0;
  logic       relu_en = 1'b0;
  wire        mem_w, mem_sel, done, out_valid;
  wire  [7:0] address_bus;
  wire [31:0] data_bus;
  wire  [3:0] ctl = {mem_sel, mem_w, out_valid, done};

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [7:0]  wq_addr [$];
  logic [31:0] wq_data [$];

  always #5 clk = ~clk;

  relu_requant_with_mem #(
    .ACC_WIDTH    (32),
    .OUT_WIDTH    (8),
    .ADDR_WIDTH   (8),
    .DATABUS_WIDTH(32),
    .SHIFT_WIDTH  (5),
    .M            (M)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_base    (in_base),
    .out_base   (out_base),
    .shift_amt  (shift_amt),
    .relu_en    (relu_en),
    .mem_w      (mem_w),
    .mem_sel    (mem_sel),
    .done       (done),
    .out_valid  (out_valid),
    .address_bus(address_bus),
    .data_bus   (data_bus)
  );

  // Released buses read as all ones through the pull-ups.
  pullup pu_addr (address_bus);
  pullup pu_data (data_bus);

  // Memory answers reads combinationally; writes are logged at the closing edge.
  assign data_bus = (mem_sel && !mem_w) ? mem[address_bus] : 32'bz;

  always @(posedge clk) begin
    if (mem_sel === 1'b1 && mem_w === 1'b1) begin
      wq_addr.push_back(address_bus);
      wq_data.push_back(data_bus);
    end
  end

  // Reference: ReLU, round-half-up shift, clamp to [-128,127], sign-extend.
  function automatic logic [31:0] model_y(input logic [31:0] xw, input int sh, input bit rl);
    longint a, r;
    a = longint'($signed(xw));
    if (rl && a < 0) a = 0;
    if (sh == 0) r = a;
    else r = (a + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 32'(r);
  endfunction

  task automatic kick(input logic [7:0] ib, input logic [7:0] ob, input logic [4:0] sh,
                      input logic rl);
    @(negedge clk);
    in_base = ib; out_base = ob; shift_amt = sh; relu_en = rl; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble operands to show they were latched at acceptance.
    in_base = 8'($urandom); out_base = 8'($urandom);
    shift_amt = 5'($urandom); relu_en = 1'($urandom);
  endtask

  // Called just after the accepting edge; walks cycles 1..2M+2 checking the bus.
  task automatic check_run(input logic [7:0] ib, input logic [7:0] ob, input int sh,
                           input bit rl, input bit poke, input string tag, output int n0);
    logic [31:0] exp_w [M];
    n0 = wq_addr.size();
    for (int i = 0; i < M; i++) exp_w[i] = model_y(mem[8'(ib + 8'(i))], sh, rl);
    for (int c = 1; c <= 2 * M + 2; c++) begin
      int k;
      @(negedge clk);
      k = (c - 1) / 2;
      checks++;
      if (c <= 2 * M && (c % 2) == 1) begin
        if (ctl !== 4'b1000 || address_bus !== 8'(ib + 8'(k)) || data_bus !== mem[8'(ib + 8'(k))]) begin
          errors++;
          $display("FAIL %s rd cyc%0d: ctl=%b addr=%h data=%h, required ctl=1000 addr=%h data=%h",
                   tag, c, ctl, address_bus, data_bus, 8'(ib + 8'(k)), mem[8'(ib + 8'(k))]);
        end
      end else if (c <= 2 * M) begin
        if (ctl !== 4'b1110 || address_bus !== 8'(ob + 8'(k)) || data_bus !== exp_w[k]) begin
          errors++;
          $display("FAIL %s wr cyc%0d: ctl=%b addr=%h data=%h, required ctl=1110 addr=%h data=%h",
                   tag, c, ctl, address_bus, data_bus, 8'(ob + 8'(k)), exp_w[k]);
        end
      end else begin
        logic [3:0] ectl;
        ectl = (c == 2 * M + 1) ? 4'b0001 : 4'b0000;
        if (ctl !== ectl || address_bus !== 8'hFF || data_bus !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL %s idle cyc%0d: ctl=%b addr=%h data=%h, required ctl=%b buses released",
                   tag, c, ctl, address_bus, data_bus, ectl);
        end
      end
      if (poke) start = (c == 1 || c == 4 || c == 2 * M + 1);
    end
    checks++;
    if (wq_addr.size() - n0 != M) begin
      errors++;
      $display("FAIL %s write count: %0d, required %0d", tag, wq_addr.size() - n0, M);
    end
    for (int i = 0; i < M && n0 + i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[n0 + i] !== 8'(ob + 8'(i)) || wq_data[n0 + i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s log[%0d]: addr=%h data=%h, required addr=%h data=%h", tag, i,
                 wq_addr[n0 + i], wq_data[n0 + i], 8'(ob + 8'(i)), exp_w[i]);
      end
    end
  endtask

  task automatic fill_table(input logic [7:0] ib);
    int tbl [M] = '{0, 1, -1, 100, -100, 1000, -1000, 127};
    for (int i = 0; i < M; i++) mem[8'(ib + 8'(i))] = 32'(tbl[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ctl !== 4'b0000 || address_bus !== 8'hFF || data_bus !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset: ctl=%b addr=%h data=%h, required 0000 and released buses",
               ctl, address_bus, data_bus);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle: ctl=%b, required 0000", ctl);
    end
  endtask

  task automatic test_passthrough();
    int n0;
    int tbl [M] = '{0, 1, -1, 100, -100, 127, -128, 127};
    fill_table(8'h20);
    kick(8'h20, 8'h40, 5'd0, 1'b0);
    check_run(8'h20, 8'h40, 0, 1'b0, 1'b0, "passthrough", n0);
    for (int i = 0; i < M && n0 + i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[n0 + i] !== 32'(tbl[i])) begin
        errors++;
        $display("FAIL passthrough_tbl[%0d]: %h, required %h", i, wq_data[n0 + i], 32'(tbl[i]));
      end
    end
  endtask

  task automatic test_relu();
    int n0;
    int tbl [M] = '{0, 1, 0, 100, 0, 127, 0, 127};
    fill_table(8'h20);
    kick(8'h20, 8'h48, 5'd0, 1'b1);
    check_run(8'h20, 8'h48, 0, 1'b1, 1'b0, "relu", n0);
    for (int i = 0; i < M && n0 + i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[n0 + i] !== 32'(tbl[i]) || wq_data[n0 + i][31] !== 1'b0) begin
        errors++;
        $display("FAIL relu_tbl[%0d]: %h, required %h", i, wq_data[n0 + i], 32'(tbl[i]));
      end
    end
  endtask

  task automatic test_rounding();
    int n0;
    int xin [5] = '{24, 23, -24, -25, 32'h7FFF_FFFF};
    int tbl [5] = '{2, 1, -1, -2, 127};
    for (int i = 0; i < M; i++) mem[8'(8'h60 + 8'(i))] = (i < 5) ? 32'(xin[i]) : $urandom;
    kick(8'h60, 8'hA0, 5'd4, 1'b0);
    check_run(8'h60, 8'hA0, 4, 1'b0, 1'b0, "rounding", n0);
    for (int i = 0; i < 5 && n0 + i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[n0 + i] !== 32'(tbl[i])) begin
        errors++;
        $display("FAIL rounding_tbl[%0d]: %h, required %h", i, wq_data[n0 + i], 32'(tbl[i]));
      end
    end
  endtask

  task automatic test_wrap();
    int n0;
    for (int i = 0; i < M; i++) mem[8'(8'h10 + 8'(i))] = $urandom;
    kick(8'h10, 8'hFC, 5'd2, 1'b0);
    check_run(8'h10, 8'hFC, 2, 1'b0, 1'b0, "wrap", n0);
  endtask

  task automatic test_random();
    int n0;
    for (int r = 0; r < 4; r++) begin
      logic [7:0] ib;
      logic [4:0] sh;
      logic       rl;
      ib = 8'($urandom); sh = 5'($urandom); rl = 1'($urandom);
      for (int i = 0; i < M; i++) begin
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(1) == 1) v = 32'($signed(v) >>> $urandom_range(31));
        mem[8'(ib + 8'(i))] = v;
      end
      kick(ib, 8'(ib + 8'h80), sh, rl);
      check_run(ib, 8'(ib + 8'h80), int'(sh), rl, 1'b0, "random", n0);
    end
  endtask

  task automatic test_reset_mid_run();
    int n0;
    logic [31:0] e0, e1;
    fill_table(8'h20);
    e0 = model_y(mem[8'h20], 3, 1'b0);
    e1 = model_y(mem[8'h21], 3, 1'b0);
    kick(8'h20, 8'hC0, 5'd3, 1'b0);
    n0 = wq_addr.size();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== 4'b0000 || address_bus !== 8'hFF || data_bus !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL midrun_reset: ctl=%b addr=%h data=%h, required 0000 and released buses",
               ctl, address_bus, data_bus);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wq_addr.size() - n0 != 2) begin
      errors++;
      $display("FAIL midrun_writes: %0d, required 2", wq_addr.size() - n0);
    end else begin
      checks++;
      if (wq_addr[n0] !== 8'hC0 || wq_addr[n0 + 1] !== 8'hC1 ||
          wq_data[n0] !== e0 || wq_data[n0 + 1] !== e1) begin
        errors++;
        $display("FAIL midrun_data: %h@%h %h@%h, required %h@c0 %h@c1", wq_data[n0],
                 wq_addr[n0], wq_data[n0 + 1], wq_addr[n0 + 1], e0, e1);
      end
    end
    kick(8'h20, 8'hC0, 5'd3, 1'b0);
    check_run(8'h20, 8'hC0, 3, 1'b0, 1'b0, "after_reset", n0);
  endtask

  task automatic test_start_ignored();
    int n0;
    for (int i = 0; i < M; i++) mem[8'(8'h30 + 8'(i))] = $urandom;
    kick(8'h30, 8'hB0, 5'd7, 1'b1);
    check_run(8'h30, 8'hB0, 7, 1'b1, 1'b1, "start_poke", n0);
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0000) begin
      errors++;
      $display("FAIL start_poke_no_rerun: ctl=%b, required 0000", ctl);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    for (int i = 0; i < M; i++) mem[8'(8'h50 + 8'(i))] = $urandom;
    @(negedge clk);
    in_base = 8'h50; out_base = 8'hD0; shift_amt = 5'd5; relu_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    check_run(8'h50, 8'hD0, 5, 1'b0, 1'b0, "b2b_first", n0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_run(8'h50, 8'hD0, 5, 1'b0, 1'b0, "b2b_second", n0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_passthrough();
    test_relu();
    test_rounding();
    test_wrap();
    test_random();
    test_reset_mid_run();
    test_start_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
